iomem_xbar: RTL
===============

Name: iomem_xbar

Overview:
Parametrised iomem fabric that replaces the hand-coded address decode in the board top level. It accepts one PicoRV32-style iomem master and fans requests out to NSLV slave channels. Each slave owns a fixed 2^SLOT_LOG2-byte window above BASE. Every transaction is registered, and a per-transaction watchdog bounds slave latency. Unmapped or timed-out accesses complete with DEFAULT_RDATA and an error pulse, so the CPU never hangs.

Parameters:
NSLV, 4, number of slave channels (1..16)
BASE, 32'h0300_0000, byte address of slot 0
SLOT_LOG2, 12, log2 of slot size in bytes (slot k = BASE + k<<SLOT_LOG2)
TIMEOUT, 255, max cycles a slave may hold a request before forced completion (1..65535)
DEFAULT_RDATA, 32'h1311_2077, read data returned on unmapped/timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
iomem_valid  in  1  master request
iomem_ready  out  1  one-cycle completion pulse to master
iomem_wstrb  in  4  byte strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
s_valid  out  NSLV  one-hot slave request
s_ready  in  NSLV  slave completion, sampled only on selected channel
s_wstrb  out  4  registered strobes (shared)
s_addr  out  SLOT_LOG2  registered byte offset within slot (shared)
s_wdata  out  32  registered write data (shared)
s_rdata  in  32*NSLV  flat slave read data, channel k at [32k+31:32k]
err  out  1  one-cycle pulse on unmapped or timeout completion

Behaviour:
- Reset, asynchronous: all outputs 0, FSM=IDLE, watchdog=0.
- FSM states: IDLE, REQ, RESP.
- IDLE, on iomem_valid: compute off = iomem_addr - BASE (32-bit wrap) and idx = off >> SLOT_LOG2.
  - Register wstrb, wdata and off[SLOT_LOG2-1:0].
  - idx < NSLV: set s_valid[idx], go to REQ.
  - Otherwise, including addr < BASE (wrap makes idx huge): load rdata=DEFAULT_RDATA, go to RESP with err.
- REQ: s_valid held, s_* stable, watchdog increments each cycle.
  - s_ready[idx]=1: capture s_rdata[idx] (writes capture it too; value is don't-care to master), clear s_valid, go to RESP.
  - Watchdog reaches TIMEOUT without s_ready: clear s_valid, rdata=DEFAULT_RDATA, flag err, go to RESP. A late s_ready after this is ignored.
  - s_ready on non-selected channels is ignored.
- RESP: iomem_ready=1 and err=flag for exactly one cycle, then IDLE. iomem_ready and err are 0 in every other state.
- IDLE ignores iomem_valid in the cycle right after RESP. This covers the master dropping valid one cycle late; no double issue.
- Latency: minimum 3 cycles from valid to ready (IDLE capture, REQ with same-cycle s_ready, RESP). A slave with zero wait states answers s_ready in the first REQ cycle.
- Watchdog width is $clog2(TIMEOUT+1). It clears on entry to REQ and never wraps.
- iomem_rdata holds its last value outside RESP. The master must sample it only on ready.
- Reset asserted mid-transaction aborts immediately: s_valid drops and no ready is issued.

Optional Feature:
IOMEM_XBAR_STATS_EN
- Defined: slot index NSLV becomes an internal read-only status register.
  - Offset 0: {16'd err_count, 16'd txn_count}, both saturating.
  - Offset 4: address of the last erroring access.
  - Writes to offset 0 clear both counters.
  - Access completes via RESP with 1-cycle REQ and no s_valid.
- Undefined: slot NSLV is unmapped like any other out-of-range slot.

Decomposition:
- Package iomem_pkg:
  - IOMEM_DW=32, IOMEM_AW=32.
  - typedef for FSM state enum.
  - DEFAULT_RDATA constant.
  - Stats register offsets.
- Sub-module iomem_watchdog: load/enable/expire counter parameterised by TIMEOUT. Reusable by future bridges.

Test Plan:
- Write 32'hA5A5_0001, wstrb=4'hF, addr 32'h0300_1004, slave 1 ready after 2 cycles -> s_valid=4'b0010, s_addr=12'h004, s_wdata matches; iomem_ready 1 cycle after s_ready; err=0.
- Read addr 32'h0300_0000, slave 0 ready in first REQ cycle with s_rdata0=32'h1234_5678 -> iomem_ready at cycle 3, rdata=32'h1234_5678.
- Read addr 32'h0300_4000 (idx 4 ≥ NSLV) and addr 32'h0200_0000 -> no s_valid; rdata=32'h1311_2077, err pulse, ready at cycle 2.
- Slave 2 never readies, TIMEOUT=8 -> s_valid high for exactly 8 cycles, then rdata=32'h1311_2077 and err; late s_ready[2] produces no second ready.
- Assert rst during REQ -> s_valid, iomem_ready and err all 0 asynchronously; the next transaction works normally.
- With IOMEM_XBAR_STATS_EN: 3 good + 2 timeout transactions, then read slot 4 offset 0 -> 32'h0002_0005 (this read is not yet counted); write offset 0 then read -> 32'h0000_0001.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem fabric: bus widths, FSM state
// encoding, fallback read data and status-register offsets.
package iomem_pkg;

  localparam int IOMEM_DW = 32;
  localparam int IOMEM_AW = 32;

  localparam logic [IOMEM_DW-1:0] IOMEM_DEFAULT_RDATA = 32'h1311_2077;

  typedef logic [1:0] iomem_state_t;
  localparam iomem_state_t ST_IDLE = 2'd0;
  localparam iomem_state_t ST_REQ  = 2'd1;
  localparam iomem_state_t ST_RESP = 2'd2;

  // Byte offsets inside the optional status slot
  localparam logic [IOMEM_AW-1:0] STAT_OFF_COUNT   = 32'h0000_0000;
  localparam logic [IOMEM_AW-1:0] STAT_OFF_ERRADDR = 32'h0000_0004;

endpackage

// File: rtl/iomem_watchdog.sv
// Per-transaction watchdog: cleared while clr is high, counts while en is
// high, and flags expire in the cycle whose increment would reach TIMEOUT.
module iomem_watchdog
  import iomem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iomem_xbar.sv
// Registered iomem fan-out to NSLV slave windows with a latency watchdog.
// Optional status slot at index NSLV when IOMEM_XBAR_STATS_EN is defined.
module iomem_xbar
  import iomem_pkg::*;
#(
  parameter int                  NSLV          = 4,
  parameter logic [IOMEM_AW-1:0] BASE          = 32'h0300_0000,
  parameter int                  SLOT_LOG2     = 12,
  parameter int                  TIMEOUT       = 255,
  parameter logic [IOMEM_DW-1:0] DEFAULT_RDATA = IOMEM_DEFAULT_RDATA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [IOMEM_AW-1:0]      iomem_addr,
  input  logic [IOMEM_DW-1:0]      iomem_wdata,
  output logic [IOMEM_DW-1:0]      iomem_rdata,
  output logic [NSLV-1:0]          s_valid,
  input  logic [NSLV-1:0]          s_ready,
  output logic [3:0]               s_wstrb,
  output logic [SLOT_LOG2-1:0]     s_addr,
  output logic [IOMEM_DW-1:0]      s_wdata,
  input  logic [IOMEM_DW*NSLV-1:0] s_rdata,
  output logic                     err
);

  iomem_state_t          state;
  logic                  err_q;
  logic                  holdoff;
  logic [IOMEM_DW-1:0]   rdata_q;
  logic [IOMEM_AW-1:0]   off;
  logic [IOMEM_AW-1:0]   idx;
  logic                  hit_slv;
  logic                  slv_ready;
  logic [IOMEM_DW-1:0]   slv_rdata;
  logic                  wd_expire;

  // Addresses below BASE wrap to a huge index and fall out as unmapped
  assign off     = iomem_addr - BASE;
  assign idx     = off >> SLOT_LOG2;
  assign hit_slv = idx < NSLV;

  assign slv_ready = |(s_ready & s_valid);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slv_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (s_valid[k]) slv_rdata = slv_rdata | s_rdata[IOMEM_DW*k +: IOMEM_DW];
    end
  end

  assign iomem_ready = (state == ST_RESP);
  assign err         = (state == ST_RESP) && err_q;
  assign iomem_rdata = rdata_q;

  iomem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ST_REQ),
    .en     (state == ST_REQ),
    .expire (wd_expire)
  );

`ifdef IOMEM_XBAR_STATS_EN
  logic                stat_sel;
  logic                hit_stat;
  logic [15:0]         txn_cnt;
  logic [15:0]         err_cnt;
  logic [IOMEM_AW-1:0] addr_q;
  logic [IOMEM_AW-1:0] last_err_addr;
  logic [IOMEM_DW-1:0] stat_rdata;

  assign hit_stat = idx == NSLV;

  always_comb begin
    stat_rdata = '0;
    if (s_addr == STAT_OFF_COUNT[SLOT_LOG2-1:0])
      stat_rdata = {err_cnt, txn_cnt};
    else if (s_addr == STAT_OFF_ERRADDR[SLOT_LOG2-1:0])
      stat_rdata = last_err_addr;
  end

  // Counters advance on the completion cycle, so a status read sees itself only afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt       <= '0;
      err_cnt       <= '0;
      addr_q        <= '0;
      last_err_addr <= '0;
    end else begin
      if (state == ST_IDLE && iomem_valid && !holdoff) addr_q <= iomem_addr;
      if (state == ST_REQ && stat_sel && s_wstrb != 4'h0 &&
          s_addr == STAT_OFF_COUNT[SLOT_LOG2-1:0]) begin
        txn_cnt <= '0;
        err_cnt <= '0;
      end else if (state == ST_RESP) begin
        if (txn_cnt != 16'hFFFF) txn_cnt <= txn_cnt + 1'b1;
        if (err_q) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
          last_err_addr <= addr_q;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_valid <= '0;
      s_wstrb <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      holdoff <= 1'b0;
`ifdef IOMEM_XBAR_STATS_EN
      stat_sel <= 1'b0;
`endif
    end else begin
      // Masks a request the master is slow to drop after ready
      holdoff <= (state == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (iomem_valid && !holdoff) begin
            s_wstrb <= iomem_wstrb;
            s_wdata <= iomem_wdata;
            s_addr  <= off[SLOT_LOG2-1:0];
            err_q   <= 1'b0;
            if (hit_slv) begin
              s_valid <= NSLV'(1) << idx;
              state   <= ST_REQ;
`ifdef IOMEM_XBAR_STATS_EN
            end else if (hit_stat) begin
              stat_sel <= 1'b1;
              state    <= ST_REQ;
`endif
            end else begin
              rdata_q <= DEFAULT_RDATA;
              err_q   <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
`ifdef IOMEM_XBAR_STATS_EN
          if (stat_sel) begin
            rdata_q  <= stat_rdata;
            stat_sel <= 1'b0;
            state    <= ST_RESP;
          end else
`endif
          if (slv_ready) begin
            rdata_q <= slv_rdata;
            s_valid <= '0;
            state   <= ST_RESP;
          end else if (wd_expire) begin
            rdata_q <= DEFAULT_RDATA;
            err_q   <= 1'b1;
            s_valid <= '0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
